cdb_issue_sched: RTL and testbench

- Parametrised successor to the fixed four-unit issue unit.
- Arbitrates NUM_CH execution channels (int, mem, mult, div, and any extra channels) for single-issue per cycle using round-robin priority.
- Each channel has its own runtime latency. A CDB-slot reservation shift register guarantees that no two results collide on the common data bus.
- Sits between dispatcher issue-ready flags and the execution units, and drives the CDB.

---
 rtl/cdb_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/cdb_issue_sched.sv | 159 +++++++++++++++
 tb/tb_cdb_issue_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_sched_pkg.sv
// Shared types and default constants for the CDB issue scheduler.
// Covers the reservation slot, the broadcast bus record and the nominal unit latencies.
package cdb_sched_pkg;

    // Channel id width sized for the largest supported configuration (8 channels)
    localparam int CH_W       = 3;
    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    localparam int LAT_INT  = 1;
    localparam int LAT_MEM  = 2;
    localparam int LAT_MULT = 4;
    localparam int LAT_DIV  = 8;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } slot_t;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter.
// The search starts at i_rr_ptr and wraps, so the first eligible channel at or above the pointer wins.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         i_eligible,
    input  logic [$clog2(NUM_CH)-1:0] i_rr_ptr,
    output logic [NUM_CH-1:0]         o_grant,
    output logic [$clog2(NUM_CH)-1:0] o_grant_idx,
    output logic                      o_grant_valid
);

    localparam int IDX_W = $clog2(NUM_CH);

    always_comb begin
        int off;
        int best_off;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        best_off      = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            off = (c + NUM_CH - int'(i_rr_ptr)) % NUM_CH;
            if (i_eligible[c] && off < best_off) begin
                best_off      = off;
                o_grant       = '0;
                o_grant[c]    = 1'b1;
                o_grant_idx   = IDX_W'(c);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_issue_sched.sv
// Round-robin issue scheduler with a CDB slot reservation shift register.
// Optional stall counter enabled by defining ISSUE_PERF_CNT_EN.
module cdb_issue_sched
    import cdb_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_CH-1:0]         i_ready,
    input  logic [NUM_CH-1:0]         i_busy,
    input  logic [NUM_CH*LAT_W-1:0]   i_ch_lat,
    input  logic                      i_flush,
    output logic [NUM_CH-1:0]         o_issue,
    input  logic [NUM_CH-1:0]         i_res_valid,
    input  logic [NUM_CH*TAG_W-1:0]   i_res_tag,
    input  logic [NUM_CH*DATA_W-1:0]  i_res_data,
    output logic                      o_cdb_valid,
    output logic [TAG_W-1:0]          o_cdb_tag,
    output logic [DATA_W-1:0]         o_cdb_data,
    output logic [$clog2(NUM_CH)-1:0] o_cdb_ch,
    output logic                      o_err,
    output logic [31:0]               o_perf_stall_cnt
);

    localparam int IDX_W = $clog2(NUM_CH);

    slot_t [MAX_LAT:0] slot_q, slot_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              err_q, err_d;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_valid;
    logic [LAT_W-1:0]  grant_lat;

    logic              sel_res_valid;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic              stray_res;

    // A channel may issue only if the CDB slot its result will land in is still free
    always_comb begin
        logic [LAT_W-1:0] lat;
        logic             slot_free;
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lat       = i_ch_lat[c*LAT_W +: LAT_W];
            slot_free = 1'b0;
            for (int k = 1; k <= MAX_LAT; k++) begin
                if (lat == LAT_W'(k)) slot_free = !slot_q[k].valid;
            end
            eligible[c] = i_ready[c] & ~i_busy[c] & ~i_flush & slot_free;
        end
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_eligible    (eligible),
        .i_rr_ptr      (rr_ptr_q),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid)
    );

    assign o_issue = grant;

    always_comb begin
        grant_lat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == IDX_W'(c)) grant_lat = i_ch_lat[c*LAT_W +: LAT_W];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Shift toward the CDB; a new reservation lands at L-1 so it reaches slot 0 after L cycles
    always_comb begin
        slot_d[MAX_LAT] = '0;
        for (int k = 0; k < MAX_LAT; k++) slot_d[k] = slot_q[k+1];
        if (grant_valid) begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                if (grant_lat == LAT_W'(k)) begin
                    slot_d[k-1].valid = 1'b1;
                    slot_d[k-1].ch    = CH_W'(grant_idx);
                end
            end
        end
    end

    always_comb begin
        logic owned;
        sel_res_valid = 1'b0;
        sel_tag       = '0;
        sel_data      = '0;
        stray_res     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            owned = slot_q[0].valid && (slot_q[0].ch == CH_W'(c));
            if (owned) begin
                sel_res_valid = i_res_valid[c];
                sel_tag       = i_res_tag[c*TAG_W +: TAG_W];
                sel_data      = i_res_data[c*DATA_W +: DATA_W];
            end else if (i_res_valid[c]) begin
                stray_res = 1'b1;
            end
        end
    end

    assign o_cdb_valid = slot_q[0].valid & sel_res_valid;
    assign o_cdb_tag   = o_cdb_valid ? sel_tag  : '0;
    assign o_cdb_data  = o_cdb_valid ? sel_data : '0;
    assign o_cdb_ch    = IDX_W'(slot_q[0].ch);

    assign err_d = err_q | (slot_q[0].valid & ~sel_res_valid) | stray_res;
    assign o_err = err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the slot array is a handful of flops, not RAM, so it is reset explicitly to drop all reservations.
            slot_q   <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (|(i_ready & ~i_busy)) & ~grant_valid & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_perf_stall_cnt = stall_cnt_q;
`else
    assign o_perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cdb_issue_sched.sv
// Self-checking bench for cdb_issue_sched: directed scenarios followed by random traffic,
// all compared against a cycle-indexed reservation model.
module tb_cdb_issue_sched;
    import cdb_sched_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int MAX_LAT = 8;
    localparam int LAT_W   = 4;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = $clog2(NUM_CH);

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic [NUM_CH-1:0]        i_ready = '0;
    logic [NUM_CH-1:0]        i_busy = '0;
    logic [NUM_CH*LAT_W-1:0]  i_ch_lat = '0;
    logic                     i_flush = 1'b0;
    logic [NUM_CH-1:0]        o_issue;
    logic [NUM_CH-1:0]        i_res_valid = '0;
    logic [NUM_CH*TAG_W-1:0]  i_res_tag = '0;
    logic [NUM_CH*DATA_W-1:0] i_res_data = '0;
    logic                     o_cdb_valid;
    logic [TAG_W-1:0]         o_cdb_tag;
    logic [DATA_W-1:0]        o_cdb_data;
    logic [IDX_W-1:0]         o_cdb_ch;
    logic                     o_err;
    logic [31:0]              o_perf_stall_cnt;

    cdb_issue_sched #(
        .NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_ready          (i_ready),
        .i_busy           (i_busy),
        .i_ch_lat         (i_ch_lat),
        .i_flush          (i_flush),
        .o_issue          (o_issue),
        .i_res_valid      (i_res_valid),
        .i_res_tag        (i_res_tag),
        .i_res_data       (i_res_data),
        .o_cdb_valid      (o_cdb_valid),
        .o_cdb_tag        (o_cdb_tag),
        .o_cdb_data       (o_cdb_data),
        .o_cdb_ch         (o_cdb_ch),
        .o_err            (o_err),
        .o_perf_stall_cnt (o_perf_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs set by the scenarios
    logic [NUM_CH-1:0] ready, busy, spur_mask;
    logic              flush, drop_res, pin_payload;
    logic [TAG_W-1:0]  pay_tag;
    logic [DATA_W-1:0] pay_data;
    int                lat [NUM_CH];

    // Reference model: result due cycle -> channel
    int          due [int];
    int          t;
    int          rr;
    bit          err_m;
    logic [31:0] stall_m;

    // Values observed in the most recent cycle
    logic [NUM_CH-1:0] smp_issue;
    cdb_bus_t          smp_bus;
    logic [IDX_W-1:0]  smp_ch;
    logic              smp_err;
    logic [31:0]       smp_perf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_perf(input logic [31:0] m);
`ifdef ISSUE_PERF_CNT_EN
        return m;
`else
        return 32'd0 & m;
`endif
    endfunction

    task automatic do_reset();
        i_rst_n     = 1'b0;
        ready       = '0;
        busy        = '0;
        flush       = 1'b0;
        drop_res    = 1'b0;
        spur_mask   = '0;
        pin_payload = 1'b0;
        i_ready     = '0;
        i_busy      = '0;
        i_flush     = 1'b0;
        i_res_valid = '0;
        #1;
        check("rst_issue", o_issue, '0);
        check("rst_cdb_valid", o_cdb_valid, 0);
        check("rst_cdb_tag", o_cdb_tag, '0);
        check("rst_cdb_data", o_cdb_data, '0);
        check("rst_cdb_ch", o_cdb_ch, '0);
        check("rst_err", o_err, 0);
        check("rst_perf", o_perf_stall_cnt, '0);
        due.delete();
        t       = 0;
        rr      = 0;
        err_m   = 0;
        stall_m = '0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance the model.
    task automatic run_cycle();
        logic [TAG_W-1:0]  tag_v  [NUM_CH];
        logic [DATA_W-1:0] data_v [NUM_CH];
        logic [NUM_CH-1:0] res_v, exp_issue;
        bit                has_res, exp_v, stray;
        int                res_ch, g, ch, l;

        res_v   = spur_mask;
        has_res = due.exists(t);
        res_ch  = has_res ? due[t] : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            tag_v[k]  = TAG_W'($urandom);
            data_v[k] = $urandom;
        end
        if (has_res) begin
            if (!drop_res) res_v[res_ch] = 1'b1;
            if (pin_payload) begin
                tag_v[res_ch]  = pay_tag;
                data_v[res_ch] = pay_data;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            i_ch_lat[k*LAT_W +: LAT_W]    = LAT_W'(lat[k]);
            i_res_tag[k*TAG_W +: TAG_W]   = tag_v[k];
            i_res_data[k*DATA_W +: DATA_W] = data_v[k];
        end
        i_ready     = ready;
        i_busy      = busy;
        i_flush     = flush;
        i_res_valid = res_v;

        @(negedge i_clk);

        g = -1;
        for (int off = 0; off < NUM_CH; off++) begin
            ch = (rr + off) % NUM_CH;
            l  = lat[ch];
            if (g < 0 && ready[ch] && !busy[ch] && !flush && l >= 1 && l <= MAX_LAT && !due.exists(t + l))
                g = ch;
        end
        exp_issue = '0;
        if (g >= 0) exp_issue[g] = 1'b1;
        exp_v = has_res && res_v[res_ch];

        check("issue", o_issue, exp_issue);
        check("cdb_valid", o_cdb_valid, exp_v);
        check("cdb_tag", o_cdb_tag, exp_v ? tag_v[res_ch] : '0);
        check("cdb_data", o_cdb_data, exp_v ? data_v[res_ch] : '0);
        if (has_res) check("cdb_ch", o_cdb_ch, res_ch);
        check("err", o_err, err_m);
        check("perf", o_perf_stall_cnt, exp_perf(stall_m));

        smp_issue     = o_issue;
        smp_bus.valid = o_cdb_valid;
        smp_bus.tag   = o_cdb_tag;
        smp_bus.data  = o_cdb_data;
        smp_ch        = o_cdb_ch;
        smp_err       = o_err;
        smp_perf      = o_perf_stall_cnt;

        stray = 0;
        for (int k = 0; k < NUM_CH; k++)
            if (res_v[k] && !(has_res && k == res_ch)) stray = 1;
        if ((has_res && !res_v[res_ch]) || stray) err_m = 1;
        if (g >= 0) begin
            due[t + lat[g]] = g;
            rr = (g + 1) % NUM_CH;
        end
        if ((|(ready & ~busy)) && g < 0 && !flush && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (has_res) due.delete(t);
        t++;

        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        ready = '0;
        busy  = '0;
        flush = 1'b0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic default_lat();
        lat[0] = LAT_INT;
        lat[1] = LAT_MEM;
        lat[2] = LAT_MULT;
        lat[3] = LAT_DIV;
    endtask

    initial begin
        default_lat();
        do_reset();

        // Single int issue, result one cycle later
        idle(5);
        ready = 4'b0001;
        run_cycle();
        check("t5_issue", smp_issue, 4'b0001);
        ready       = '0;
        pin_payload = 1'b1;
        pay_tag     = 6'h0A;
        pay_data    = 32'hDEAD_BEEF;
        run_cycle();
        check("t6_cdb_valid", smp_bus.valid, 1);
        check("t6_cdb_tag", smp_bus.tag, 6'h0A);
        check("t6_cdb_data", smp_bus.data, 32'hDEAD_BEEF);
        check("t6_cdb_ch", smp_ch, 0);
        pin_payload = 1'b0;
        idle(4);

        // All channels ready: round-robin rotation
        do_reset();
        ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            check("rr_seq", smp_issue, 4'b0001 << (i % 4));
        end
        for (int i = 0; i < 8; i++) run_cycle();
        idle(10);
        check("rr_no_err", smp_err, 0);

        // Slot collision: mult result at t+4 blocks an int issue at t+3
        do_reset();
        ready = 4'b0100;
        run_cycle();
        check("col_grant2", smp_issue, 4'b0100);
        idle(2);
        ready = 4'b0001;
        run_cycle();
        check("col_deny0", smp_issue, 4'b0000);
        run_cycle();
        check("col_grant0", smp_issue, 4'b0001);
        idle(10);

        // Busy divider never granted; released busy grants at once, result 8 cycles later
        do_reset();
        ready = 4'b1000;
        busy  = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            check("busy_deny", smp_issue, 4'b0000);
        end
        busy = '0;
        run_cycle();
        check("busy_release", smp_issue, 4'b1000);
        idle(7);
        run_cycle();
        check("div_cdb_valid", smp_bus.valid, 1);
        check("div_cdb_ch", smp_ch, 3);
        idle(2);

        // Flush blocks grants but not in-flight results
        do_reset();
        ready = 4'b0010;
        run_cycle();
        ready = 4'b1111;
        flush = 1'b1;
        run_cycle();
        check("flush_issue", smp_issue, 4'b0000);
        run_cycle();
        check("flush_issue2", smp_issue, 4'b0000);
        check("flush_bcast", smp_bus.valid, 1);
        check("flush_bcast_ch", smp_ch, 1);
        idle(10);

        // Missed slot sets sticky error; async reset clears it and drops reservations
        do_reset();
        ready = 4'b0010;
        run_cycle();
        idle(1);
        drop_res = 1'b1;
        run_cycle();
        check("miss_cdb_valid", smp_bus.valid, 0);
        check("miss_err_pre", smp_err, 0);
        drop_res = 1'b0;
        ready    = 4'b1000;
        run_cycle();
        check("miss_err_set", smp_err, 1);
        idle(1);
        check("miss_err_hold", smp_err, 1);
        do_reset();
        idle(12);
        check("post_rst_err", smp_err, 0);

        // Unreserved result
        spur_mask = 4'b0100;
        run_cycle();
        spur_mask = '0;
        run_cycle();
        check("stray_err", smp_err, 1);

        // Illegal latencies never grant and count as stalls
        do_reset();
        lat[0] = 0;
        lat[1] = 12;
        ready  = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check("bad_lat_deny", smp_issue, 4'b0000);
        end
        idle(1);
        check("stall_cnt", smp_perf, exp_perf(32'd3));
        default_lat();

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                for (int k = 0; k < NUM_CH; k++)
                    lat[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, MAX_LAT);
            end
            ready = NUM_CH'($urandom);
            busy  = NUM_CH'($urandom & $urandom & $urandom);
            flush = ($urandom_range(0, 15) == 0);
            run_cycle();
        end
        idle(MAX_LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
